// File: rtl/control_sequencer_if.sv
// Datapath-side signals of the control sequencer: memory handshake, IR contents,
// strobes and register selects.
interface control_sequencer_if;
    logic        mem_ready;
    logic [31:0] ir;
    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        MDRread;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        RYin;
    logic        RZinLo;
    logic        RZoutLo;
    logic        mem_read;
    logic [15:0] Rin;
    logic [15:0] Rout;

    modport master (
        input  mem_ready, ir,
        output PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin, RYin,
               RZinLo, RZoutLo, mem_read, Rin, Rout
    );

    modport slave (
        output mem_ready, ir,
        input  PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin, RYin,
               RZinLo, RZoutLo, mem_read, Rin, Rout
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for a bus-based datapath.
// Strobes decode from the state register, ir and mem_ready only.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       run,
    control_sequencer_if.master        bus,
    output logic [3:0]                 state,
    output logic                       halted,
    output logic                       err
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        HALT = 4'd7,
        ERR  = 4'd8
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [4:0] OP_HALT = 5'b11111;
    localparam logic [4:0] OP_NOP  = 5'b11110;

    state_t      cur;
    logic [7:0]  wait_cnt;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;

    assign opcode = bus.ir[31:27];
    assign ra     = bus.ir[26:23];
    assign rb     = bus.ir[22:19];
    assign rc     = bus.ir[18:15];
    assign state  = cur;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!clear) begin
            cur      <= IDLE;
            wait_cnt <= '0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (cur)
                IDLE: if (run) cur <= T0;
                T0: begin
                    cur      <= T1;
                    wait_cnt <= '0;
                end
                T1: begin
                    if (!bus.mem_ready) wait_cnt <= wait_cnt + 8'd1;
                    // A late mem_ready still wins over an expiring timeout.
                    if (bus.mem_ready) begin
                        cur <= T2;
                    end else if (wait_cnt == TIMEOUT) begin
                        cur <= ERR;
                        err <= 1'b1;
                    end
                end
                T2: cur <= T3;
                T3: begin
                    if (opcode == OP_HALT) begin
                        cur    <= HALT;
                        halted <= 1'b1;
                    end else if (opcode == OP_NOP) begin
                        cur <= run ? T0 : IDLE;
                    end else begin
                        cur <= T4;
                    end
                end
                T4: cur <= T5;
                T5: cur <= run ? T0 : IDLE;
                HALT, ERR: ;
                default: cur <= IDLE;
            endcase
        end
    end

    // In T3, ir already holds the word loaded by IRin at the end of T2.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MDRread  = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.RYin     = 1'b0;
        bus.RZinLo   = 1'b0;
        bus.RZoutLo  = 1'b0;
        bus.mem_read = 1'b0;
        bus.Rin      = '0;
        bus.Rout     = '0;
        case (cur)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            T1: begin
                bus.mem_read = 1'b1;
                bus.MDRread  = 1'b1;
                bus.MDRin    = bus.mem_ready;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                if (opcode != OP_HALT && opcode != OP_NOP) begin
                    bus.Rout = 16'd1 << rb;
                    bus.RYin = 1'b1;
                end
            end
            T4: begin
                bus.Rout   = 16'd1 << rc;
                bus.RZinLo = 1'b1;
            end
            T5: begin
                bus.RZoutLo = 1'b1;
                bus.Rin     = 16'd1 << ra;
            end
            default: ;
        endcase
    end

endmodule
